// File: rtl/prim_lfsr_period_mon.sv
// Period and lockup monitor for a prim_lfsr instance: captures a reference state on start,
// counts LFSR steps until it recurs, and reports period, lockup, timeout or mismatch.
module prim_lfsr_period_mon #(
  parameter int unsigned      LfsrDw    = 8,
  parameter string            LfsrType  = "GAL_XOR",
  parameter int unsigned      CntDw     = LfsrDw + 1,
  parameter logic [CntDw-1:0] ExpPeriod = CntDw'({LfsrDw{1'b1}}),
  parameter logic [CntDw-1:0] MaxCnt    = CntDw'({1'b1, {LfsrDw{1'b0}}})
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              valid_i,
  input  logic [LfsrDw-1:0] state_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CntDw-1:0]  period_o,
  output logic              pass_o,
  output logic              err_lockup_o,
  output logic              err_timeout_o,
  output logic              err_period_o
);

  // Galois XOR LFSRs lock up at all-zeros, Fibonacci XNOR LFSRs at all-ones.
  localparam logic [LfsrDw-1:0] Lockup = (LfsrType == "FIB_XNOR") ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LfsrDw-1:0]  ref_q, ref_d;
  logic [CntDw-1:0]   cnt_q, cnt_d;
  logic [CntDw-1:0]   period_q, period_d;
  logic               pass_q, pass_d;
  logic               lock_q, lock_d;
  logic               to_q, to_d;
  logic               perr_q, perr_d;
  logic [CntDw-1:0]   nxt;

  assign nxt = cnt_q + CntDw'(1);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pass_d   = pass_q;
    lock_d   = lock_q;
    to_d     = to_q;
    perr_d   = perr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          ref_d    = state_i;
          cnt_d    = '0;
          period_d = '0;
          pass_d   = 1'b0;
          to_d     = 1'b0;
          perr_d   = 1'b0;
          lock_d   = (state_i == Lockup);
          state_d  = (state_i == Lockup) ? REPORT : RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (valid_i) begin
          if (state_i == Lockup) begin
            lock_d  = 1'b1;
            state_d = REPORT;
          end else if (state_i == ref_q) begin
            period_d = nxt;
            pass_d   = (nxt == ExpPeriod);
            perr_d   = (nxt != ExpPeriod);
            state_d  = REPORT;
          end else if (nxt == MaxCnt) begin
            to_d     = 1'b1;
            period_d = MaxCnt;
            state_d  = REPORT;
          end else begin
            cnt_d = nxt;
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
        // An abort here discards the result just produced.
        if (abort_i) begin
          period_d = '0;
          pass_d   = 1'b0;
          lock_d   = 1'b0;
          to_d     = 1'b0;
          perr_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      pass_q   <= 1'b0;
      lock_q   <= 1'b0;
      to_q     <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pass_q   <= pass_d;
      lock_q   <= lock_d;
      to_q     <= to_d;
      perr_q   <= perr_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == REPORT);
  assign period_o      = period_q;
  assign pass_o        = pass_q;
  assign err_lockup_o  = lock_q;
  assign err_timeout_o = to_q;
  assign err_period_o  = perr_q;

endmodule
